// File: rtl/serv_alu_seq.sv
// Word-level sequencer for the bit-serial serv_alu: accepts a parallel request,
// streams operand slices LSB first for XLEN/W beats, reassembles the result.
module serv_alu_seq #(
  parameter int W    = 1,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_a,
  input  logic [XLEN-1:0] i_req_b,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_cmp,
  output logic            o_busy,
  output logic            o_alu_en,
  output logic            o_alu_cnt0,
  output logic            o_alu_sub,
  output logic            o_alu_cmp_eq,
  output logic            o_alu_cmp_sig,
  output logic            o_alu_buf,
  output logic [1:0]      o_alu_bool_op,
  output logic [2:0]      o_alu_rd_sel,
  output logic [W-1:0]    o_alu_rs1,
  output logic [W-1:0]    o_alu_op_b,
  input  logic [W-1:0]    i_alu_rd,
  input  logic            i_alu_cmp
);

  localparam int BEATS = XLEN / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [2:0] rd_sel;
    logic       sub;
    logic [1:0] bool_op;
    logic       cmp_eq;
    logic       cmp_sig;
    logic       is_cmp;   // result word is the compare flag, not rd
  } ctrl_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] a_sr, b_sr, res;
  ctrl_t           ctrl, dec;
  logic            accept, last_beat;

  assign accept    = i_req_valid && (state == IDLE);
  assign last_beat = (state == RUN) && (cnt == LAST);

  // Op decode into serv_alu control fields
  always_comb begin
    dec = '0;
    case (i_req_op)
      3'b000: dec.rd_sel = 3'b001;
      3'b001: begin dec.rd_sel = 3'b001; dec.sub = 1'b1; end
      3'b010: dec.rd_sel = 3'b100;
      3'b011: begin dec.rd_sel = 3'b100; dec.bool_op = 2'b10; end
      3'b100: begin dec.rd_sel = 3'b100; dec.bool_op = 2'b11; end
      3'b101: begin dec.rd_sel = 3'b001; dec.sub = 1'b1; dec.cmp_sig = 1'b1; dec.is_cmp = 1'b1; end
      3'b110: begin dec.rd_sel = 3'b001; dec.sub = 1'b1; dec.is_cmp = 1'b1; end
      default: begin dec.rd_sel = 3'b001; dec.sub = 1'b1; dec.cmp_eq = 1'b1; dec.is_cmp = 1'b1; end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and all handshake / ALU-control outputs
  always_comb begin
    state_nxt     = state;
    o_req_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    o_rsp_data    = '0;
    o_busy        = 1'b0;
    o_alu_en      = 1'b0;
    o_alu_cnt0    = 1'b0;
    o_alu_sub     = 1'b0;
    o_alu_cmp_eq  = 1'b0;
    o_alu_cmp_sig = 1'b0;
    o_alu_buf     = 1'b0;
    o_alu_bool_op = '0;
    o_alu_rd_sel  = '0;
    o_alu_rs1     = '0;
    o_alu_op_b    = '0;
    case (state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        o_busy        = 1'b1;
        o_alu_en      = 1'b1;
        o_alu_cnt0    = (cnt == '0);
        o_alu_sub     = ctrl.sub;
        o_alu_cmp_eq  = ctrl.cmp_eq;
        o_alu_cmp_sig = ctrl.cmp_sig;
        o_alu_bool_op = ctrl.bool_op;
        o_alu_rd_sel  = ctrl.rd_sel;
        o_alu_rs1     = a_sr[W-1:0];
        o_alu_op_b    = b_sr[W-1:0];
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        o_busy      = 1'b1;
        o_rsp_valid = 1'b1;
        o_rsp_data  = ctrl.is_cmp ? {{(XLEN-1){1'b0}}, o_rsp_cmp} : res;
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, result collector, beat counter, latched controls
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      ctrl      <= '0;
      o_rsp_cmp <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      a_sr <= i_req_a;
      b_sr <= i_req_b;
      ctrl <= dec;
    end else if (state == RUN) begin
      a_sr <= a_sr >> W;
      b_sr <= b_sr >> W;
      res  <= {i_alu_rd, res[XLEN-1:W]};
      cnt  <= last_beat ? '0 : cnt + 1'b1;
      if (last_beat) o_rsp_cmp <= i_alu_cmp;
    end
  end

endmodule

// File: tb/tb_serv_alu_seq.sv
// Directed bench for serv_alu_seq (XLEN=32, W=1) with a behavioural
// bit-serial ALU standing in for serv_alu.
module tb_serv_alu_seq;
  localparam int XLEN = 32;
  localparam int W    = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0, req_ready;
  logic [2:0]      req_op = '0;
  logic [XLEN-1:0] req_a = '0, req_b = '0;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_cmp, busy;
  logic            alu_en, alu_cnt0, alu_sub, alu_cmp_eq, alu_cmp_sig, alu_buf;
  logic [1:0]      alu_bool_op;
  logic [2:0]      alu_rd_sel;
  logic [W-1:0]    alu_rs1, alu_op_b, alu_rd;
  logic            alu_cmp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serv_alu_seq #(.W(W), .XLEN(XLEN)) dut (
    .clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_cmp(rsp_cmp), .o_busy(busy),
    .o_alu_en(alu_en), .o_alu_cnt0(alu_cnt0), .o_alu_sub(alu_sub),
    .o_alu_cmp_eq(alu_cmp_eq), .o_alu_cmp_sig(alu_cmp_sig), .o_alu_buf(alu_buf),
    .o_alu_bool_op(alu_bool_op), .o_alu_rd_sel(alu_rd_sel),
    .o_alu_rs1(alu_rs1), .o_alu_op_b(alu_op_b),
    .i_alu_rd(alu_rd), .i_alu_cmp(alu_cmp)
  );

  // Serial ALU model: ripple carry and running equality held across beats
  logic cy_r = 1'b0, eq_r = 1'b0;
  logic ci, co, sum, bres, eq_now, lt_now;
  always_comb begin
    ci          = alu_cnt0 ? alu_sub : cy_r;
    {co, sum}   = 2'(alu_rs1[0]) + 2'(alu_op_b[0] ^ alu_sub) + 2'(ci);
    bres        = ((alu_rs1[0] ^ alu_op_b[0]) & ~alu_bool_op[0]) |
                  (alu_bool_op[1] & alu_rs1[0] & alu_op_b[0]);
    eq_now      = (alu_cnt0 ? 1'b1 : eq_r) & ~sum;
    lt_now      = (alu_cmp_sig && (alu_rs1[0] != alu_op_b[0])) ? alu_rs1[0] : ~co;
    alu_cmp     = alu_cmp_eq ? eq_now : lt_now;
    alu_rd[0]   = (alu_rd_sel[0] & sum) | (alu_rd_sel[1] & lt_now) | (alu_rd_sel[2] & bres);
  end
  always_ff @(posedge clk) if (alu_en) begin
    cy_r <= co;
    eq_r <= eq_now;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-op bookkeeping from the most recent do_op
  int          lat;
  int          en_cycles, cnt0_cycles;
  logic        cnt0_first;
  logic [31:0] got_data;
  logic        got_cmp;

  // Issue one request, wait for the response, handshake it.
  // lat counts negedge samples; sample 0 is the cycle the request is accepted.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = -1; en_cycles = 0; cnt0_cycles = 0; cnt0_first = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (alu_en) begin
        if (alu_cnt0) cnt0_cycles++;
        if (en_cycles == 0) cnt0_first = alu_cnt0;
        en_cycles++;
      end
      if (rsp_valid) begin lat = n; break; end
    end
    if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
    got_data = rsp_data; got_cmp = rsp_cmp;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, exp_data;
    logic        exp_cmp;
    logic        use_cmp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"add_1_0",     3'b000, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
    vecs[1]  = '{"add_wrap",    3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{"sub_5_5",     3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0};
    vecs[3]  = '{"sub_0_1",     3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[4]  = '{"and",         3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0};
    vecs[5]  = '{"or",          3'b011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hFFFF0F0F, 1'b0, 1'b0};
    vecs[6]  = '{"xor",         3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0};
    vecs[7]  = '{"slt_m1_1",    3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b1};
    vecs[8]  = '{"sltu_m1_1",   3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1};
    vecs[9]  = '{"eq_7_7",      3'b111, 32'h00000007, 32'h00000007, 32'h00000001, 1'b1, 1'b1};
    vecs[10] = '{"eq_7_6",      3'b111, 32'h00000007, 32'h00000006, 32'h00000000, 1'b0, 1'b1};
    vecs[11] = '{"add_big",     3'b000, 32'h7FFFFFFF, 32'h12345678, 32'h92345677, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_alu_en",    32'(alu_en),    32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven ops: data, compare flag, response latency, single cnt0
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, "_data"}, got_data, vecs[i].exp_data);
      if (vecs[i].use_cmp) chk({vecs[i].name, "_cmp"}, 32'(got_cmp), 32'(vecs[i].exp_cmp));
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'd33);
      chk({vecs[i].name, "_en_cycles"}, 32'(en_cycles), 32'd32);
      chk({vecs[i].name, "_cnt0"}, {31'd0, cnt0_first} + 32'(cnt0_cycles << 1), 32'd3);
      chk({vecs[i].name, "_idle_after"}, {30'd0, busy, req_ready}, 32'd1);
    end

    // Back-pressure in DONE: response held stable, no new accept
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b000; req_a = 32'd10; req_b = 32'd20;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int n = 0; n < 200 && !rsp_valid; n++) @(negedge clk);
    chk("bp_reached_done", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_a = 32'd1; req_b = 32'd1;
    begin
      int bad = 0;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== 32'd30 || req_ready) bad++;
      end
      chk("bp_stable_10cyc", 32'(bad), 32'd0);
    end
    chk("bp_data", rsp_data, 32'd30);
    rsp_ready = 1'b1;                 // handshake with req_valid still high
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("bp_idle_after_hs", {30'd0, busy, req_ready}, 32'd1);

    // Asynchronous reset at beat 10 of RUN, then a clean op
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b111; req_a = 32'd9; req_b = 32'd9;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_alu_en",    32'(alu_en),    32'd0);
    chk("midrst_busy",      32'(busy),      32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_cmp",   32'(rsp_cmp),   32'd0);
    @(negedge clk); rst = 1'b0;
    do_op(3'b000, 32'd2, 32'd3);
    chk("post_rst_add", got_data, 32'd5);
    chk("post_rst_latency", 32'(lat), 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
